branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 24 ++
 rtl/branch_resolver_cond_eval.sv | 33 +++
 rtl/branch_resolver.sv | 136 +++++++++++++
 tb/tb_branch_resolver.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared condition-code constants and FSM state type for the
// branch resolver and its condition evaluator.
package branch_resolver_pkg;

  localparam logic [1:0] COND_F   = 2'b00;
  localparam logic [1:0] COND_EQ  = 2'b01;
  localparam logic [1:0] COND_LT  = 2'b10;
  localparam logic [1:0] COND_LTE = 2'b11;

  localparam int COND_ZERO_BIT = 2;
  localparam int COND_INV_BIT  = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REPORT
  } state_t;

  function automatic logic uses_alu(input logic [3:0] cond);
    return cond[1:0] != COND_F;
  endfunction

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// Combinational branch condition evaluation from an ALU difference.
// The F/T selector ignores the difference entirely.
module cond_eval
  import branch_resolver_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic [1:0]       sel,
  input  logic             invert,
  input  logic [DBITS-1:0] diff,
  output logic             taken
);

  logic eq;
  logic lt;
  logic base;

  assign eq = (diff == '0);
  assign lt = diff[DBITS-1];

  always_comb begin
    base = 1'b0;
    unique case (sel)
      COND_EQ:  base = eq;
      COND_LT:  base = lt;
      COND_LTE: base = eq | lt;
      default:  base = 1'b0;
    endcase
  end

  assign taken = invert ? ~base : base;

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: captures a branch, asks the ALU for rs1-rs2,
// evaluates the condition and reports taken / next PC to fetch.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [3:0]       br_cond,
  input  logic [DBITS-1:0] br_rs1,
  input  logic [DBITS-1:0] br_rs2,
  input  logic [DBITS-1:0] br_pc,
  input  logic [DBITS-1:0] br_imm,
  output logic             alu_req_valid,
  input  logic             alu_req_ready,
  output logic [DBITS-1:0] alu_a,
  output logic [DBITS-1:0] alu_b,
  input  logic             alu_rsp_valid,
  input  logic [DBITS-1:0] alu_rsp_diff,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic             redir_taken,
  output logic [DBITS-1:0] redir_pc,
  input  logic             flush
);

  state_t           state;
  logic [3:0]       cond_q;
  logic [DBITS-1:0] rs1_q;
  logic [DBITS-1:0] rs2_q;
  logic [DBITS-1:0] pc_q;
  logic [DBITS-1:0] imm_q;

  logic [3:0]       ev_cond;
  logic [DBITS-1:0] ev_pc;
  logic [DBITS-1:0] ev_imm;
  logic             ev_taken;
  logic [DBITS-1:0] seq_pc;
  logic [DBITS-1:0] tgt_pc;
  logic [DBITS-1:0] next_pc;

  // In IDLE an F/T branch resolves straight from the request inputs
  assign ev_cond = (state == S_IDLE) ? br_cond : cond_q;
  assign ev_pc   = (state == S_IDLE) ? br_pc   : pc_q;
  assign ev_imm  = (state == S_IDLE) ? br_imm  : imm_q;

  cond_eval #(
    .DBITS(DBITS)
  ) u_cond_eval (
    .sel    (ev_cond[1:0]),
    .invert (ev_cond[COND_INV_BIT]),
    .diff   (alu_rsp_diff),
    .taken  (ev_taken)
  );

  assign seq_pc  = ev_pc + DBITS'(4);
  assign tgt_pc  = seq_pc + (ev_imm << 2);
  assign next_pc = ev_taken ? tgt_pc : seq_pc;

  assign alu_a = rs1_q;
  assign alu_b = cond_q[COND_ZERO_BIT] ? '0 : rs2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      br_ready      <= 1'b1;
      alu_req_valid <= 1'b0;
      redir_valid   <= 1'b0;
      redir_taken   <= 1'b0;
      redir_pc      <= '0;
      cond_q        <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
    end else if (flush) begin
      state         <= S_IDLE;
      br_ready      <= 1'b1;
      alu_req_valid <= 1'b0;
      redir_valid   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (br_valid) begin
            cond_q   <= br_cond;
            rs1_q    <= br_rs1;
            rs2_q    <= br_rs2;
            pc_q     <= br_pc;
            imm_q    <= br_imm;
            br_ready <= 1'b0;
            if (uses_alu(br_cond)) begin
              state         <= S_ISSUE;
              alu_req_valid <= 1'b1;
            end else begin
              state       <= S_REPORT;
              redir_valid <= 1'b1;
              redir_taken <= ev_taken;
              redir_pc    <= next_pc;
            end
          end
        end
        S_ISSUE: begin
          if (alu_req_ready) begin
            state         <= S_WAIT;
            alu_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (alu_rsp_valid) begin
            state       <= S_REPORT;
            redir_valid <= 1'b1;
            redir_taken <= ev_taken;
            redir_pc    <= next_pc;
          end
        end
        S_REPORT: begin
          if (redir_ready) begin
            state       <= S_IDLE;
            redir_valid <= 1'b0;
            br_ready    <= 1'b1;
          end
        end
        default: begin
          state         <= S_IDLE;
          br_ready      <= 1'b1;
          alu_req_valid <= 1'b0;
          redir_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed branches, ALU model,
// stalls, flush and reset-in-flight scenarios.
module tb_branch_resolver;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } alu_exp_t;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
  } redir_exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        br_valid;
  logic        br_ready;
  logic [3:0]  br_cond;
  logic [31:0] br_rs1;
  logic [31:0] br_rs2;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        alu_req_valid;
  logic        alu_req_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_rsp_valid;
  logic [31:0] alu_rsp_diff;
  logic        redir_valid;
  logic        redir_ready;
  logic        redir_taken;
  logic [31:0] redir_pc;
  logic        flush;

  int checks = 0;
  int errors = 0;
  int alu_delay = 0;

  alu_exp_t   aq[$];
  redir_exp_t sb[$];

  branch_resolver #(
    .DBITS(32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .br_valid      (br_valid),
    .br_ready      (br_ready),
    .br_cond       (br_cond),
    .br_rs1        (br_rs1),
    .br_rs2        (br_rs2),
    .br_pc         (br_pc),
    .br_imm        (br_imm),
    .alu_req_valid (alu_req_valid),
    .alu_req_ready (alu_req_ready),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_rsp_valid (alu_rsp_valid),
    .alu_rsp_diff  (alu_rsp_diff),
    .redir_valid   (redir_valid),
    .redir_ready   (redir_ready),
    .redir_taken   (redir_taken),
    .redir_pc      (redir_pc),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // ALU model: accepts, then pulses the difference after alu_delay+1 edges
  initial begin
    alu_exp_t e;
    logic [31:0] d;
    logic fire;
    alu_rsp_valid = 1'b0;
    alu_rsp_diff  = '0;
    forever begin
      @(negedge clk);
      fire = reset_n && alu_req_valid && alu_req_ready;
      if (fire) begin
        d = '0;
        if (aq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL alu_unexpected: a=0x%0h b=0x%0h, required no request",
                   alu_a, alu_b);
        end else begin
          e = aq.pop_front();
          chk("alu_a", alu_a, e.a);
          chk("alu_b", alu_b, e.b);
          d = e.a - e.b;
        end
        repeat (alu_delay + 1) @(posedge clk);
        #1;
        alu_rsp_valid = 1'b1;
        alu_rsp_diff  = d;
        @(posedge clk);
        #1;
        alu_rsp_valid = 1'b0;
        alu_rsp_diff  = '0;
      end
    end
  end

  // Redirect monitor
  initial begin
    redir_exp_t r;
    forever begin
      @(negedge clk);
      if (reset_n && redir_valid && redir_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL redir_unexpected: pc=0x%0h taken=%0d, required none",
                   redir_pc, redir_taken);
        end else begin
          r = sb.pop_front();
          chk("redir_taken", {31'b0, redir_taken}, {31'b0, r.taken});
          chk("redir_pc", redir_pc, r.pc);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] p,
                       input logic [31:0] im, input logic tk,
                       input logic [31:0] npc, input bit want_redir);
    int n = 0;
    while (!br_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!br_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: br_ready=0 after %0d cycles, required 1", n);
    end
    if (c[1:0] != 2'b00)
      aq.push_back(alu_exp_t'{a: r1, b: (c[2] ? 32'h0 : r2)});
    if (want_redir)
      sb.push_back(redir_exp_t'{taken: tk, pc: npc});
    br_valid = 1'b1;
    br_cond  = c;
    br_rs1   = r1;
    br_rs2   = r2;
    br_pc    = p;
    br_imm   = im;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !br_ready) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d redirects pending, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic latency(input string nm, input int exp);
    int lat = 1;
    while (!redir_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(nm, lat, exp);
  endtask

  initial begin
    reset_n       = 1'b0;
    br_valid      = 1'b0;
    br_cond       = '0;
    br_rs1        = '0;
    br_rs2        = '0;
    br_pc         = '0;
    br_imm        = '0;
    alu_req_ready = 1'b1;
    redir_ready   = 1'b1;
    flush         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_br_ready", {31'b0, br_ready}, 32'h1);
    chk("rst_alu_req_valid", {31'b0, alu_req_valid}, 32'h0);
    chk("rst_redir_valid", {31'b0, redir_valid}, 32'h0);
    chk("rst_redir_taken", {31'b0, redir_taken}, 32'h0);
    chk("rst_redir_pc", redir_pc, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // EQ taken, 3-cycle latency
    issue(4'b0001, 32'd5, 32'd5, 32'h100, 32'd3, 1'b1, 32'h110, 1'b1);
    latency("lat_compare", 3);
    drain();
    // LT against zero
    issue(4'b0110, 32'hFFFFFFFF, 32'd7, 32'h300, 32'd5, 1'b1, 32'h318, 1'b1);
    drain();
    issue(4'b0110, 32'd1, 32'd7, 32'h300, 32'd5, 1'b0, 32'h304, 1'b1);
    drain();
    // Always-taken, no ALU, 1-cycle latency
    issue(4'b1000, 32'h0, 32'h0, 32'h200, 32'hFFFFFFFE, 1'b1, 32'h1FC, 1'b1);
    latency("lat_ft", 1);
    drain();
    issue(4'b0000, 32'd1, 32'd1, 32'h40, 32'd9, 1'b0, 32'h44, 1'b1);
    drain();
    issue(4'b0001, 32'd3, 32'd4, 32'h1000, 32'd8, 1'b0, 32'h1004, 1'b1);
    drain();
    issue(4'b0010, 32'd3, 32'd9, 32'h80, 32'd2, 1'b1, 32'h8C, 1'b1);
    drain();
    issue(4'b1011, 32'd9, 32'd3, 32'h90, 32'h100, 1'b1, 32'h494, 1'b1);
    drain();
    issue(4'b1001, 32'd6, 32'd6, 32'hA0, 32'd4, 1'b0, 32'hA4, 1'b1);
    drain();
    issue(4'b0111, 32'd0, 32'd5, 32'h10, 32'd0, 1'b1, 32'h14, 1'b1);
    drain();
    // PC wraparound
    issue(4'b0001, 32'd2, 32'd2, 32'hFFFFFFFC, 32'd1, 1'b1, 32'h4, 1'b1);
    drain();
    issue(4'b0000, 32'd0, 32'd0, 32'hFFFFFFFC, 32'd1, 1'b0, 32'h0, 1'b1);
    drain();

    // ALU backpressure: request held stable
    alu_req_ready = 1'b0;
    issue(4'b0011, 32'h10, 32'h20, 32'h400, 32'h10, 1'b1, 32'h444, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("stall_req_valid", {31'b0, alu_req_valid}, 32'h1);
      chk("stall_a", alu_a, 32'h10);
      chk("stall_b", alu_b, 32'h20);
      @(posedge clk);
      #1;
    end
    alu_req_ready = 1'b1;
    drain();

    // Flush in WAIT; late response lands in IDLE
    alu_delay = 1;
    issue(4'b0001, 32'd7, 32'd7, 32'h600, 32'd1, 1'b1, 32'h608, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_br_ready", {31'b0, br_ready}, 32'h1);
    chk("flush_late_rsp", {31'b0, alu_rsp_valid}, 32'h1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("flush_no_redir", {31'b0, redir_valid}, 32'h0);
    end
    alu_delay = 0;

    // Flush beats a simultaneous capture
    br_valid = 1'b1;
    br_cond  = 4'b1000;
    br_pc    = 32'h700;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_cap_ready", {31'b0, br_ready}, 32'h1);
    chk("flush_cap_redir", {31'b0, redir_valid}, 32'h0);

    // Reset while a result waits for the consumer
    redir_ready = 1'b0;
    issue(4'b1000, 32'h0, 32'h0, 32'h500, 32'd1, 1'b1, 32'h508, 1'b0);
    @(negedge clk);
    chk("hold_valid", {31'b0, redir_valid}, 32'h1);
    chk("hold_pc", redir_pc, 32'h508);
    @(posedge clk);
    #1;
    chk("hold_pc2", redir_pc, 32'h508);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rstmid_redir_valid", {31'b0, redir_valid}, 32'h0);
    chk("rstmid_br_ready", {31'b0, br_ready}, 32'h1);
    chk("rstmid_redir_pc", redir_pc, 32'h0);
    redir_ready = 1'b1;
    @(posedge clk);
    #1;

    issue(4'b0001, 32'd11, 32'd11, 32'h800, 32'd2, 1'b1, 32'h80C, 1'b1);
    drain();
    chk("alu_queue_empty", aq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
